// File: rtl/pipe_ctrl_unit.sv
// Control sequencer for the 5-stage pipeline: ID decode, per-stage control
// registers, load-use stall, branch flush and halt sequencing.
module pipe_ctrl_unit #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              mem_zero,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_branch,
  output logic              pc_src,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              halted
);

  typedef struct packed {
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       regDst;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       regWrite;
    logic       memToReg;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t BUBBLE = ctrl_t'({3'b111, 8'b0000_0000});

  ctrl_t              idCtrl;
  ctrl_t              idex, exmem, memwb;
  ctrl_t              nIdex, nExmem, nMemwb;
  logic [REG_AW-1:0]  idexRt;
  logic               haltPending, nHaltPending;
  logic               branchTaken, loadUse;

  // Flag order below: aluSrc regDst memRead memWrite branch regWrite memToReg halt
  always_comb begin
    idCtrl = BUBBLE;
    unique case (id_opcode)
      4'h0:    idCtrl = ctrl_t'({3'b000, 8'b0100_0100});
      4'h2:    idCtrl = ctrl_t'({3'b010, 8'b1000_0100});
      4'h3:    idCtrl = ctrl_t'({3'b011, 8'b1000_0100});
      4'h4:    idCtrl = ctrl_t'({3'b100, 8'b1010_0110});
      4'h5:    idCtrl = ctrl_t'({3'b100, 8'b1001_0000});
      4'h8:    idCtrl = ctrl_t'({3'b011, 8'b0000_1000});
      4'hF:    idCtrl = ctrl_t'({3'b111, 8'b0000_0001});
      default: idCtrl = BUBBLE;
    endcase
  end

  assign branchTaken = exmem.branch & mem_zero;
  // r0 deliberately takes part in the hazard compare
  assign loadUse     = idex.memRead & ((idexRt == id_rs) | (idexRt == id_rt));

  always_comb begin
    nIdex        = idCtrl;
    nExmem       = idex;
    nMemwb       = exmem;
    nHaltPending = haltPending;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    if (halted) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      nIdex      = BUBBLE;
      nExmem     = BUBBLE;
      nMemwb     = BUBBLE;
    end else if (branchTaken) begin
      // the branch itself still retires into MEM/WB
      ifid_flush   = 1'b1;
      nIdex        = BUBBLE;
      nExmem       = BUBBLE;
      nHaltPending = 1'b0;
    end else if (loadUse || haltPending) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      nIdex      = BUBBLE;
    end else if (idCtrl.halt) begin
      nHaltPending = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex        <= BUBBLE;
      exmem       <= BUBBLE;
      memwb       <= BUBBLE;
      idexRt      <= '0;
      haltPending <= 1'b0;
      halted      <= 1'b0;
    end else begin
      idex        <= nIdex;
      exmem       <= nExmem;
      memwb       <= nMemwb;
      idexRt      <= id_rt;
      haltPending <= nHaltPending;
      // sets on the same edge that MEM/WB captures the halt bit
      halted      <= halted | exmem.halt;
    end
  end

  assign ex_alu_op     = idex.aluOp;
  assign ex_alu_src    = idex.aluSrc;
  assign ex_reg_dst    = idex.regDst;
  assign mem_read      = exmem.memRead;
  assign mem_write     = exmem.memWrite;
  assign mem_branch    = exmem.branch;
  assign pc_src        = branchTaken;
  assign wb_reg_write  = memwb.regWrite;
  assign wb_mem_to_reg = memwb.memToReg;

  logic unusedWb;
  assign unusedWb = ^{memwb.aluOp, memwb.aluSrc, memwb.regDst, memwb.memRead,
                      memwb.memWrite, memwb.branch, memwb.halt};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: per-cycle vector table plus hand sequences for
// halt and asynchronous reset, expected outputs flow through a queue.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_opcode;
  logic [2:0] id_rs, id_rt;
  logic       mem_zero;
  logic [2:0] ex_alu_op;
  logic       ex_alu_src, ex_reg_dst, mem_read, mem_write, mem_branch, pc_src;
  logic       wb_reg_write, wb_mem_to_reg, pc_write, ifid_write, ifid_flush, halted;

  pipe_ctrl_unit #(.REG_AW(3)) dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .mem_zero(mem_zero), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_branch(mem_branch), .pc_src(pc_src), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef logic [14:0] obs_t;
  typedef struct {
    logic [3:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       z;
    obs_t       exp;
    string      name;
  } vec_t;

  obs_t expQ[$];
  vec_t tbl[$];
  int   nVec = 0;
  int   nErr = 0;
  obs_t obs;
  obs_t BUB, HOLD, HLTD;

  assign obs = {ex_alu_op, ex_alu_src, ex_reg_dst, mem_read, mem_write, mem_branch,
                pc_src, wb_reg_write, wb_mem_to_reg, pc_write, ifid_write, ifid_flush, halted};

  function automatic obs_t mk(int a, bit s, bit d, bit mr, bit mw, bit br, bit ps,
                              bit rw, bit m2r, bit pw, bit iw, bit fl, bit h);
    logic [2:0] a3;
    a3 = a[2:0];
    return {a3, s, d, mr, mw, br, ps, rw, m2r, pw, iw, fl, h};
  endfunction

  task automatic add(logic [3:0] op, logic [2:0] rs, logic [2:0] rt, logic z,
                     obs_t exp, string name);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.z = z; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(string name);
    obs_t e;
    nVec++;
    if (expQ.size() == 0) begin
      nErr++;
      $display("FAIL %s: scoreboard empty, got %h", name, obs);
    end else begin
      e = expQ.pop_front();
      if (obs !== e) begin
        nErr++;
        $display("FAIL %s: got %h required %h", name, obs, e);
      end
    end
  endtask

  task automatic driveNow(logic [3:0] op, logic [2:0] rs, logic [2:0] rt, logic z,
                          obs_t exp, string name);
    id_opcode = op; id_rs = rs; id_rt = rt; mem_zero = z;
    expQ.push_back(exp);
    #2;
    check(name);
  endtask

  task automatic step(logic [3:0] op, logic [2:0] rs, logic [2:0] rt, logic z,
                      obs_t exp, string name);
    @(negedge clk);
    driveNow(op, rs, rt, z, exp, name);
  endtask

  initial begin
    BUB  = mk(7, 0,0, 0,0,0, 0, 0,0, 1,1,0, 0);
    HOLD = mk(7, 0,0, 0,0,0, 0, 0,0, 0,0,0, 0);
    HLTD = mk(7, 0,0, 0,0,0, 0, 0,0, 0,0,0, 1);

    // R-type latency
    add(4'h0, 3'd1, 3'd2, 0, BUB,                               "r_issue");
    add(4'h1, 3'd0, 3'd0, 0, mk(0, 0,1, 0,0,0, 0, 0,0, 1,1,0, 0), "r_ex");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "r_mem");
    add(4'h1, 3'd0, 3'd0, 0, mk(7, 0,0, 0,0,0, 0, 1,0, 1,1,0, 0), "r_wb");
    // load-use on rs
    add(4'h4, 3'd0, 3'd3, 0, BUB,                               "lw_issue");
    add(4'h0, 3'd3, 3'd1, 0, mk(4, 1,0, 0,0,0, 0, 0,0, 0,0,0, 0), "lu_stall");
    add(4'h0, 3'd3, 3'd1, 0, mk(7, 0,0, 1,0,0, 0, 0,0, 1,1,0, 0), "lu_bubble_ex");
    add(4'h1, 3'd0, 3'd0, 0, mk(0, 0,1, 0,0,0, 0, 1,1, 1,1,0, 0), "lu_r_issued");
    // no stall when neither source matches
    add(4'h4, 3'd0, 3'd3, 0, BUB,                               "lw2_issue");
    add(4'h0, 3'd5, 3'd5, 0, mk(4, 1,0, 0,0,0, 0, 1,0, 1,1,0, 0), "nostall");
    add(4'h1, 3'd0, 3'd0, 0, mk(0, 0,1, 1,0,0, 0, 0,0, 1,1,0, 0), "nostall_r_ex");
    add(4'h1, 3'd0, 3'd0, 0, mk(7, 0,0, 0,0,0, 0, 1,1, 1,1,0, 0), "nostall_lw_wb");
    add(4'h1, 3'd0, 3'd0, 0, mk(7, 0,0, 0,0,0, 0, 1,0, 1,1,0, 0), "nostall_r_wb");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "drain1");
    // load-use through rt with register 0
    add(4'h4, 3'd1, 3'd0, 0, BUB,                               "lw_r0_issue");
    add(4'h5, 3'd2, 3'd0, 0, mk(4, 1,0, 0,0,0, 0, 0,0, 0,0,0, 0), "r0_stall");
    add(4'h5, 3'd2, 3'd0, 0, mk(7, 0,0, 1,0,0, 0, 0,0, 1,1,0, 0), "r0_bubble");
    add(4'h1, 3'd0, 3'd0, 0, mk(4, 1,0, 0,0,0, 0, 1,1, 1,1,0, 0), "sw_ex");
    add(4'h1, 3'd0, 3'd0, 0, mk(7, 0,0, 0,1,0, 0, 0,0, 1,1,0, 0), "sw_mem");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "sw_wb");
    // taken branch
    add(4'h8, 3'd0, 3'd0, 0, BUB,                               "beq_issue");
    add(4'h0, 3'd6, 3'd7, 0, mk(3, 0,0, 0,0,0, 0, 0,0, 1,1,0, 0), "beq_ex");
    add(4'h2, 3'd6, 3'd7, 1, mk(0, 0,1, 0,0,1, 1, 0,0, 1,1,1, 0), "beq_taken");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "beq_flushed");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "beq_drain");
    // untaken branch
    add(4'h8, 3'd0, 3'd0, 0, BUB,                               "beqn_issue");
    add(4'h0, 3'd6, 3'd7, 0, mk(3, 0,0, 0,0,0, 0, 0,0, 1,1,0, 0), "beqn_ex");
    add(4'h2, 3'd6, 3'd7, 0, mk(0, 0,1, 0,0,1, 0, 0,0, 1,1,0, 0), "beqn_mem");
    add(4'h1, 3'd0, 3'd0, 0, mk(2, 1,0, 0,0,0, 0, 0,0, 1,1,0, 0), "andi_ex");
    add(4'h1, 3'd0, 3'd0, 0, mk(7, 0,0, 0,0,0, 0, 1,0, 1,1,0, 0), "beqn_r_wb");
    add(4'h1, 3'd0, 3'd0, 0, mk(7, 0,0, 0,0,0, 0, 1,0, 1,1,0, 0), "andi_wb");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "beqn_drain");
    // HALT in ID while branch taken
    add(4'h8, 3'd0, 3'd0, 0, BUB,                               "bh_issue");
    add(4'h1, 3'd0, 3'd0, 0, mk(3, 0,0, 0,0,0, 0, 0,0, 1,1,0, 0), "bh_ex");
    add(4'hF, 3'd0, 3'd0, 1, mk(7, 0,0, 0,0,1, 1, 0,0, 1,1,1, 0), "bh_taken");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "bh_halt_flushed");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "bh_not_halted1");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "bh_not_halted2");
    add(4'h1, 3'd0, 3'd0, 0, BUB,                               "bh_not_halted3");
    // HALT issue
    add(4'hF, 3'd0, 3'd0, 0, BUB,                               "halt_issue");
    add(4'h0, 3'd1, 3'd1, 0, HOLD,                              "halt_pend1");
    add(4'h0, 3'd1, 3'd1, 0, HOLD,                              "halt_pend2");
    add(4'h0, 3'd1, 3'd1, 0, HLTD,                              "halted_set");

    rst = 1'b1;
    id_opcode = 4'h1; id_rs = '0; id_rt = '0; mem_zero = 1'b0;
    #12;
    expQ.push_back(BUB);
    check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i])
      step(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].z, tbl[i].exp, tbl[i].name);

    // halted is sticky whatever arrives in ID
    for (int k = 0; k < 22; k++)
      step(4'($urandom_range(15)), 3'($urandom_range(7)), 3'($urandom_range(7)),
           1'($urandom_range(1)), HLTD, "halted_hold");

    // async reset while halted, then issue on first edge after release
    @(negedge clk);
    #1 rst = 1'b1;
    id_opcode = 4'h1; id_rs = '0; id_rt = '0; mem_zero = 1'b0;
    expQ.push_back(BUB);
    #1 check("rst_while_halted");
    @(negedge clk);
    rst = 1'b0;
    driveNow(4'h0, 3'd1, 3'd2, 0, BUB, "resume_issue");
    step(4'h1, 3'd0, 3'd0, 0, mk(0, 0,1, 0,0,0, 0, 0,0, 1,1,0, 0), "resume_r_ex");

    // async reset during an active stall
    step(4'h4, 3'd0, 3'd3, 0, BUB, "lw3_issue");
    step(4'h0, 3'd3, 3'd3, 0, mk(4, 1,0, 0,0,0, 0, 1,0, 0,0,0, 0), "lw3_stall");
    #1 rst = 1'b1;
    id_opcode = 4'h1; id_rs = '0; id_rt = '0;
    expQ.push_back(BUB);
    #1 check("rst_during_stall");
    @(negedge clk);
    rst = 1'b0;
    driveNow(4'h2, 3'd1, 3'd2, 0, BUB, "resume2_issue");
    step(4'h1, 3'd0, 3'd0, 0, mk(2, 1,0, 0,0,0, 0, 0,0, 1,1,0, 0), "resume2_andi_ex");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Central control sequencer for the 5-stage pipeline.
- Decodes the ID-stage opcode into per-stage control, including the 3-bit ALU op consumed by the ALU control decoder in EX.
- Carries that control through ID/EX, EX/MEM and MEM/WB control registers.
- Generates load-use stall, branch flush and halt sequencing for the PC and IF/ID registers.

Parameters:
REG_AW, 3, width of register-specifier fields rs/rt.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous reset, active-high.
id_opcode  in  4  opcode of the instruction in IF/ID.
id_rs  in  REG_AW  source register specifier in IF/ID.
id_rt  in  REG_AW  second source/destination specifier in IF/ID.
mem_zero  in  1  ALU zero flag registered in EX/MEM.
ex_alu_op  out  3  ALU op to the ALU control decoder.
ex_alu_src  out  1  1 = immediate operand.
ex_reg_dst  out  1  1 = rd destination, 0 = rt.
mem_read  out  1  data memory read.
mem_write  out  1  data memory write.
mem_branch  out  1  branch instruction in MEM.
pc_src  out  1  select branch target (combinational = mem_branch & mem_zero).
wb_reg_write  out  1  register file write.
wb_mem_to_reg  out  1  writeback from memory.
pc_write  out  1  PC load enable.
ifid_write  out  1  IF/ID load enable.
ifid_flush  out  1  clear IF/ID to NOP at next edge.
halted  out  1  sticky, processor halted.

Behaviour:
- Decode table (ID, combinational), listing alu_op, alu_src, reg_dst, mem_read, mem_write, branch, reg_write, mem_to_reg:
  - 0x0 R-type: 000,0,1,0,0,0,1,0.
  - 0x2 ANDI: 010,1,0,0,0,0,1,0.
  - 0x3 ORI: 011,1,0,0,0,0,1,0.
  - 0x4 LW: 100,1,0,1,0,0,1,1.
  - 0x5 SW: 100,1,0,0,1,0,0,0.
  - 0x8 BEQ: 011,0,0,0,0,1,0,0.
  - 0xF HALT: alu_op 111, all flags 0, halt bit set.
  - Any other opcode is a NOP: alu_op 111, all flags 0.
- Bubble = all control bits 0, alu_op 111, halt bit 0.
- Pipelining:
  - Decoded control plus id_rt register into the ID/EX stage at each edge.
  - Then EX/MEM, then MEM/WB.
  - Latency from ID to EX outputs is 1 cycle, to MEM outputs 2 cycles, to WB outputs 3 cycles.
- Reset (async): all stage registers become bubbles; halted=0; halt_pending=0. The combinational outputs then read pc_write=1, ifid_write=1, ifid_flush=0, pc_src=0.
- Branch taken (mem_branch & mem_zero), highest priority:
  - pc_src=1, pc_write=1, ifid_flush=1, ifid_write=1.
  - ID/EX and EX/MEM load bubbles at the next edge.
  - MEM/WB loads the branch's own control normally.
  - halt_pending clears.
  - The load-use stall is ignored in the same cycle.
- Load-use stall, applied when not taken. Condition: ID/EX mem_read=1 and ID/EX rt equals id_rs or id_rt.
  - Register 0 is not exempt.
  - pc_write=0, ifid_write=0, ID/EX loads a bubble.
  - EX/MEM and MEM/WB advance normally.
  - Lasts exactly 1 cycle for a single LW.
- Halt:
  - When HALT decodes in ID with no taken branch and no stall, it issues into ID/EX and halt_pending sets.
  - While halt_pending=1: pc_write=0, ifid_write=0, ID issues bubbles (the held HALT is not re-issued).
  - When the halt bit reaches MEM/WB, halted sets.
  - halted stays set until rst. While halted: pc_write=0, ifid_write=0, all stages load bubbles.
- A HALT in ID in the same cycle as a taken branch is flushed. halt_pending stays 0.
- Reset asserted mid-stall, mid-flush or while halted returns immediately to the reset state.

Test Plan:
- Reset then R-type (0x0) in ID → next cycle ex_alu_op=000, ex_reg_dst=1; 2 cycles later wb_reg_write=1, wb_mem_to_reg=0.
- LW (0x4, rt=3) followed by R-type with id_rs=3 → one cycle with pc_write=0, ifid_write=0 and a bubble in EX (ex_alu_op=111). Then the R-type issues. The same sequence with rs=rt=5 gives no stall.
- BEQ (0x8) reaching MEM with mem_zero=1 → pc_src=1, ifid_flush=1; next cycle ex_* and mem_* outputs are bubbles. With mem_zero=0: no flush, pc_src=0.
- HALT issued → pc_write=0 from the next cycle; halted=1 exactly 3 cycles after issue and stays 1 for 20+ cycles with ifid_write=0.
- Taken BEQ in MEM while HALT is in ID → HALT flushed, halted stays 0, pc_write=1.
- rst pulsed while halted=1 and during an active stall → all outputs return to reset values asynchronously; normal issue resumes on the first edge after deassertion.
